// File: rtl/i2c_target_ctrl.sv
// i2c_target_ctrl: I2C target with a 7-bit address and an internal register file.
// SCL/SDA are oversampled on clk; SDA is only ever pulled low (open drain).
//   clk, rst_n        system clock, synchronous active-low reset
//   scl_i, sda_i      raw pad inputs (asynchronous)
//   sda_oe            1 = pull SDA low, 0 = release
//   busy              addressed transaction in progress
//   wr_valid/addr/data one-clk commit strobe for each written register byte
module i2c_target_ctrl #(
  parameter logic [6:0]  TARGET_ADDR = 7'h55,
  parameter int unsigned MEM_DEPTH   = 128,
  parameter logic [7:0]  RST_VAL     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_valid,
  output logic [6:0] wr_addr,
  output logic [7:0] wr_data
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] tx_q, tx_d;
  logic [6:0] ptr_q, ptr_d;
  logic       sda_oe_q, sda_oe_d;
  logic       busy_q, busy_d;
  logic       wr_valid_q, wr_valid_d;
  logic [6:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       mem_we;

  logic [7:0] mem_q [MEM_DEPTH];

  logic scl_rise, scl_fall, start_det, stop_det;
  logic ptr_in_range;
  logic [7:0] rd_byte;

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
  assign stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;

  if (MEM_DEPTH >= 128) begin : g_full
    assign ptr_in_range = 1'b1;
  end else begin : g_part
    assign ptr_in_range = 32'(ptr_q) < MEM_DEPTH;
  end

  assign rd_byte = ptr_in_range ? mem_q[ptr_q] : 8'hFF;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      cnt_d    = '0;
    end else if (start_det) begin
      state_d  = ADDR;
      sda_oe_d = 1'b0;
      cnt_d    = '0;
    end else begin
      if (scl_rise && (state_q == ADDR || state_q == PTR || state_q == WDATA)) begin
        shift_d = {shift_q[6:0], sda_s2_q};
        cnt_d   = cnt_q + 4'd1;
      end
      case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = '0;
            if (shift_q[7:1] == TARGET_ADDR) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              state_d  = ADDR_ACK;
            end else begin
              busy_d  = 1'b0;
              state_d = IGNORE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            // shift_q[0] still holds R/W: no bits are shifted during ACK.
            if (shift_q[0]) begin
              sda_oe_d = ~rd_byte[7];
              tx_d     = {rd_byte[6:0], 1'b0};
              cnt_d    = 4'd1;
              state_d  = RDATA;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = PTR;
            end
          end
        end
        PTR: begin
          if (scl_fall && cnt_q == 4'd8) begin
            ptr_d    = shift_q[6:0];
            sda_oe_d = 1'b1;
            cnt_d    = '0;
            state_d  = PTR_ACK;
          end
        end
        PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = WDATA;
          end
        end
        WDATA: begin
          if (scl_fall && cnt_q == 4'd8) begin
            mem_we     = ptr_in_range;
            wr_valid_d = 1'b1;
            wr_addr_d  = ptr_q;
            wr_data_d  = shift_q;
            ptr_d      = ptr_q + 7'd1;
            sda_oe_d   = 1'b1;
            cnt_d      = '0;
            state_d    = WDATA_ACK;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 7'd1;
              cnt_d    = '0;
              state_d  = RDATA_ACK;
            end else begin
              sda_oe_d = ~tx_q[7];
              tx_d     = {tx_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end
        RDATA_ACK: begin
          // cnt_q == 1 marks a master ACK seen on the rise; the next byte starts on the fall.
          if (scl_rise) begin
            if (sda_s2_q) state_d = IGNORE;
            else          cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            sda_oe_d = ~rd_byte[7];
            tx_d     = {rd_byte[6:0], 1'b0};
            cnt_d    = 4'd1;
            state_d  = RDATA;
          end
        end
        IGNORE: sda_oe_d = 1'b0;
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_s1_q   <= 1'b1;
      scl_s2_q   <= 1'b1;
      scl_h_q    <= 1'b1;
      sda_s1_q   <= 1'b1;
      sda_s2_q   <= 1'b1;
      sda_h_q    <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= RST_VAL;
    end else begin
      scl_s1_q   <= scl_i;
      scl_s2_q   <= scl_s1_q;
      scl_h_q    <= scl_s2_q;
      sda_s1_q   <= sda_i;
      sda_s2_q   <= sda_s1_q;
      sda_h_q    <= sda_s2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= shift_q;
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Bench for i2c_target_ctrl: a bit-level I2C master drives the bus, and a
// register-file model (array + pointer) predicts ACKs, commits and read data.
module tb_i2c_target_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       scl_i, sda_i, sda_oe, busy, wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad = 0;

  logic [7:0] ref_mem [128];
  logic [6:0] ref_ptr;
  logic [6:0] wq_addr [$];
  logic [7:0] wq_data [$];
  logic [7:0] wbuf [8];

  assign scl_i = m_scl;
  assign sda_i = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_ctrl #(
    .TARGET_ADDR(7'h55),
    .MEM_DEPTH  (128),
    .RST_VAL    (8'h00)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .scl_i   (scl_i),
    .sda_i   (sda_i),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_valid(wr_valid),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      wq_addr.push_back(wr_addr);
      wq_data.push_back(wr_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clk_bit(input logic b, output logic s);
    ticks(6); m_sda = b;
    ticks(6); m_scl = 1'b1;
    ticks(4); s = sda_i;
    ticks(4); m_scl = 1'b0;
  endtask

  task automatic start_c();
    ticks(6); m_sda = 1'b1;
    ticks(6); m_scl = 1'b1;
    ticks(8); m_sda = 1'b0;
    ticks(8); m_scl = 1'b0;
  endtask

  task automatic stop_c();
    ticks(6); m_sda = 1'b0;
    ticks(6); m_scl = 1'b1;
    ticks(8); m_sda = 1'b1;
    ticks(8);
  endtask

  task automatic put_byte(input logic [7:0] v, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(v[i], s);
    clk_bit(1'b1, s);
    acked = ~s;
  endtask

  task automatic get_byte(input logic ack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      v[i] = s;
    end
    clk_bit(~ack, s);
  endtask

  task automatic wr_txn(input logic [6:0] p, input int n);
    logic a;
    logic [6:0] ea;
    wq_addr.delete();
    wq_data.delete();
    start_c();
    put_byte({7'h55, 1'b0}, a);
    check("wr addr ack", 32'(a), 1);
    check("busy after match", 32'(busy), 1);
    put_byte({1'b0, p}, a);
    check("wr ptr ack", 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      put_byte(wbuf[i], a);
      check("wr data ack", 32'(a), 1);
    end
    stop_c();
    check("busy after stop", 32'(busy), 0);
    check("sda_oe after stop", 32'(sda_oe), 0);
    check("wr_valid count", 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      ea = p + 7'(i);
      ref_mem[ea] = wbuf[i];
      if (i < wq_addr.size()) begin
        check("wr_addr", 32'(wq_addr[i]), 32'(ea));
        check("wr_data", 32'(wq_data[i]), 32'(wbuf[i]));
      end
    end
    ref_ptr = p + 7'(n);
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [6:0] p, input int n);
    logic a;
    logic [7:0] v;
    logic [6:0] ea;
    if (set_ptr) begin
      start_c();
      put_byte({7'h55, 1'b0}, a);
      check("rd wr-addr ack", 32'(a), 1);
      put_byte({1'b0, p}, a);
      check("rd ptr ack", 32'(a), 1);
      ref_ptr = p;
    end
    start_c();
    put_byte({7'h55, 1'b1}, a);
    check("rd addr ack", 32'(a), 1);
    for (int i = 0; i < n; i++) begin
      get_byte(i != n - 1, v);
      ea = ref_ptr + 7'(i);
      check("rd data", 32'(v), 32'(ref_mem[ea]));
    end
    check("sda released after nack", 32'(sda_oe), 0);
    stop_c();
    ref_ptr = ref_ptr + 7'(n);
  endtask

  initial begin
    logic a;
    logic s;
    logic [6:0] p;
    int n;

    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    ref_ptr = '0;

    // reset state
    ticks(4);
    check("reset sda_oe", 32'(sda_oe), 0);
    check("reset busy", 32'(busy), 0);
    check("reset wr_valid", 32'(wr_valid), 0);
    check("reset wr_addr", 32'(wr_addr), 0);
    check("reset wr_data", 32'(wr_data), 0);
    rst_n = 1'b1;
    ticks(4);

    // seed 0x12 so the pointer-after-read check is meaningful
    wbuf[0] = 8'($urandom_range(1, 255));
    wr_txn(7'h12, 1);

    // write 0x3C, 0x5A at 0x10, read them back, then read current address 0x12
    wbuf[0] = 8'h3C;
    wbuf[1] = 8'h5A;
    wr_txn(7'h10, 2);
    rd_txn(1'b1, 7'h10, 2);
    check("ptr after read", 32'(ref_ptr), 32'h12);
    rd_txn(1'b0, 7'h00, 1);

    // address mismatch, then a repeated START to our address
    wq_addr.delete();
    wq_data.delete();
    start_c();
    put_byte(8'hA8, a);
    check("mismatch no ack", 32'(a), 0);
    check("mismatch busy", 32'(busy), 0);
    put_byte(8'h5A, a);
    check("ignored byte no ack", 32'(a), 0);
    check("mismatch no wr", 32'(wq_addr.size()), 0);
    wbuf[0] = 8'hC3;
    wr_txn(7'h40, 1);

    // pointer wrap
    wbuf[0] = 8'h01;
    wbuf[1] = 8'h02;
    wr_txn(7'h7F, 2);
    check("ptr wrapped", 32'(ref_ptr), 32'h01);
    rd_txn(1'b1, 7'h7F, 2);

    // STOP after 4 data bits discards the byte
    wbuf[0] = 8'h96;
    wr_txn(7'h20, 1);
    wq_addr.delete();
    wq_data.delete();
    start_c();
    put_byte({7'h55, 1'b0}, a);
    check("partial addr ack", 32'(a), 1);
    put_byte(8'h20, a);
    check("partial ptr ack", 32'(a), 1);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    clk_bit(1'b0, s);
    clk_bit(1'b1, s);
    stop_c();
    check("partial no wr", 32'(wq_addr.size()), 0);
    check("partial sda_oe", 32'(sda_oe), 0);
    check("partial busy", 32'(busy), 0);
    rd_txn(1'b1, 7'h20, 1);

    // randomized write/read-back traffic
    for (int k = 0; k < 10; k++) begin
      p = 7'($urandom);
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
      wr_txn(p, n);
      rd_txn(1'b1, p, n);
      if (k % 2 == 1) rd_txn(1'b0, 7'h00, $urandom_range(1, 2));
    end

    // reset during a read byte: 0x3C has MSB 0, so the target pulls SDA low first
    wbuf[0] = 8'h3C;
    wr_txn(7'h10, 1);
    start_c();
    put_byte({7'h55, 1'b0}, a);
    check("rst-test wr ack", 32'(a), 1);
    put_byte(8'h10, a);
    check("rst-test ptr ack", 32'(a), 1);
    start_c();
    put_byte({7'h55, 1'b1}, a);
    check("rst-test rd ack", 32'(a), 1);
    ticks(6);
    check("drive before reset", 32'(sda_oe), 1);
    rst_n = 1'b0;
    ticks(1);
    check("mid reset sda_oe", 32'(sda_oe), 0);
    check("mid reset busy", 32'(busy), 0);
    check("mid reset wr_valid", 32'(wr_valid), 0);
    check("mid reset wr_addr", 32'(wr_addr), 0);
    check("mid reset wr_data", 32'(wr_data), 0);
    rst_n = 1'b1;
    for (int i = 0; i < 128; i++) ref_mem[i] = 8'h00;
    ref_ptr = '0;
    stop_c();
    rd_txn(1'b1, 7'h10, 1);
    rd_txn(1'b1, 7'h7F, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
